// File: rtl/raid_rebuild_ctrl.sv
// Rebuilds one failed SD card of a three-card XOR set, stripe by stripe:
// read the two survivors into a 128-word buffer, then write the buffer to the failed card.
module raid_rebuild_ctrl (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic [1:0]  failed_sd,
   input  logic [31:0] base_blk,
   input  logic [10:0] stripe_cnt,
   input  logic        sd_ready,
   input  logic [5:0]  sd_error,
   input  logic [31:0] sd1out,
   input  logic [31:0] sd2out,
   input  logic [31:0] sd3out,
   input  logic [31:0] buf_r_data,
   output logic        sd_start,
   output logic        sd_mode,
   output logic [2:0]  sd_sel,
   output logic [31:0] sd_block_no,
   output logic        sd_load_enable,
   output logic [31:0] sd_wdata,
   output logic        buf_w_enable,
   output logic        buf_r_enable,
   output logic [6:0]  buf_addr,
   output logic [31:0] buf_w_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [10:0] stripes_done
);

   typedef enum logic [2:0] {
      IDLE, RD_START, RD_XFER, WR_START, WR_XFER, NEXT, DONE, ERR
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  fsd_q, fsd_d;
   logic [31:0] base_q, base_d;
   logic [10:0] cnt_q, cnt_d;
   logic [10:0] sdone_q, sdone_d;
   logic [6:0]  word_q, word_d;
   logic [1:0]  retry_q, retry_d;
   logic        error_q, error_d;

   logic [2:0]  fail_oh;
   logic [2:0]  surv;
   logic [2:0]  xfer_sel;
   logic        err_hit;
   logic [31:0] rd_xor;

   always_comb begin
      fail_oh = 3'b000;
      case (fsd_q)
         2'd1:    fail_oh = 3'b001;
         2'd2:    fail_oh = 3'b010;
         2'd3:    fail_oh = 3'b100;
         default: fail_oh = 3'b000;
      endcase
   end

   assign surv     = ~fail_oh;
   assign xfer_sel = (state_q == RD_XFER) ? surv : fail_oh;
   // Only cards taking part in the current transfer can fail it.
   assign err_hit  = ((|sd_error[1:0]) & xfer_sel[0]) |
                     ((|sd_error[3:2]) & xfer_sel[1]) |
                     ((|sd_error[5:4]) & xfer_sel[2]);
   assign rd_xor   = (surv[0] ? sd1out : 32'd0) ^
                     (surv[1] ? sd2out : 32'd0) ^
                     (surv[2] ? sd3out : 32'd0);

   assign sd_block_no  = base_q + {21'd0, sdone_q};
   assign busy         = (state_q != IDLE);
   assign error        = error_q;
   assign stripes_done = sdone_q;

   // sd_ready=1 means exactly one word moved this cycle; an error in the same cycle voids it.
   always_comb begin
      state_d        = state_q;
      fsd_d          = fsd_q;
      base_d         = base_q;
      cnt_d          = cnt_q;
      sdone_d        = sdone_q;
      word_d         = word_q;
      retry_d        = retry_q;
      error_d        = error_q;
      sd_start       = 1'b0;
      sd_mode        = 1'b0;
      sd_sel         = 3'b000;
      sd_load_enable = 1'b0;
      sd_wdata       = 32'd0;
      buf_w_enable   = 1'b0;
      buf_r_enable   = 1'b0;
      buf_addr       = 7'd0;
      buf_w_data     = 32'd0;
      done           = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (failed_sd != 2'd0)) begin
               fsd_d   = failed_sd;
               base_d  = base_blk;
               cnt_d   = stripe_cnt;
               sdone_d = 11'd0;
               word_d  = 7'd0;
               retry_d = 2'd0;
               error_d = 1'b0;
               state_d = (stripe_cnt != 11'd0) ? RD_START : DONE;
            end
         end
         RD_START: begin
            sd_start = 1'b1;
            sd_sel   = surv;
            state_d  = RD_XFER;
         end
         RD_XFER: begin
            buf_addr   = word_q;
            buf_w_data = rd_xor;
            if (err_hit) begin
               word_d = 7'd0;
               if (retry_q == 2'd2) begin
                  error_d = 1'b1;
                  state_d = ERR;
               end else begin
                  retry_d = retry_q + 2'd1;
                  state_d = RD_START;
               end
            end else if (sd_ready) begin
               sd_load_enable = 1'b1;
               buf_w_enable   = 1'b1;
               word_d         = word_q + 7'd1;
               if (word_q == 7'd127) begin
                  retry_d = 2'd0;
                  state_d = WR_START;
               end
            end
         end
         WR_START: begin
            sd_start = 1'b1;
            sd_mode  = 1'b1;
            sd_sel   = fail_oh;
            state_d  = WR_XFER;
         end
         WR_XFER: begin
            buf_r_enable = 1'b1;
            buf_addr     = word_q;
            sd_wdata     = buf_r_data;
            if (err_hit) begin
               word_d = 7'd0;
               if (retry_q == 2'd2) begin
                  error_d = 1'b1;
                  state_d = ERR;
               end else begin
                  retry_d = retry_q + 2'd1;
                  state_d = WR_START;
               end
            end else if (sd_ready) begin
               sd_load_enable = 1'b1;
               word_d         = word_q + 7'd1;
               if (word_q == 7'd127) state_d = NEXT;
            end
         end
         NEXT: begin
            sdone_d = sdone_q + 11'd1;
            if (({1'b0, sdone_q} + 12'd1) < {1'b0, cnt_q}) begin
               retry_d = 2'd0;
               state_d = RD_START;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= IDLE;
         fsd_q   <= 2'd0;
         base_q  <= 32'd0;
         cnt_q   <= 11'd0;
         sdone_q <= 11'd0;
         word_q  <= 7'd0;
         retry_q <= 2'd0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fsd_q   <= fsd_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         sdone_q <= sdone_d;
         word_q  <= word_d;
         retry_q <= retry_d;
         error_q <= error_d;
      end
   end

endmodule

// File: tb/tb_raid_rebuild_ctrl.sv
// Randomized bench for raid_rebuild_ctrl: a procedural stripe/phase/word model predicts
// every cycle's strobes and data; expected sd_start descriptors go through exp_q.
module tb_raid_rebuild_ctrl;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start;
   logic [1:0]  failed_sd;
   logic [31:0] base_blk;
   logic [10:0] stripe_cnt;
   logic        sd_ready;
   logic [5:0]  sd_error;
   logic [31:0] sd1out, sd2out, sd3out;
   logic [31:0] buf_r_data;
   logic        sd_start, sd_mode, sd_load_enable, buf_w_enable, buf_r_enable;
   logic        busy, done, error;
   logic [2:0]  sd_sel;
   logic [31:0] sd_block_no, sd_wdata, buf_w_data;
   logic [6:0]  buf_addr;
   logic [10:0] stripes_done;

   raid_rebuild_ctrl dut (
      .clk(clk), .n_rst(n_rst), .start(start), .failed_sd(failed_sd),
      .base_blk(base_blk), .stripe_cnt(stripe_cnt), .sd_ready(sd_ready),
      .sd_error(sd_error), .sd1out(sd1out), .sd2out(sd2out), .sd3out(sd3out),
      .buf_r_data(buf_r_data), .sd_start(sd_start), .sd_mode(sd_mode),
      .sd_sel(sd_sel), .sd_block_no(sd_block_no), .sd_load_enable(sd_load_enable),
      .sd_wdata(sd_wdata), .buf_w_enable(buf_w_enable), .buf_r_enable(buf_r_enable),
      .buf_addr(buf_addr), .buf_w_data(buf_w_data), .busy(busy), .done(done),
      .error(error), .stripes_done(stripes_done)
   );

   always #5 clk = ~clk;

   // Buffer RAM with combinational read, as seen by the controller.
   logic [31:0] tb_mem [128];
   always @(posedge clk) if (buf_w_enable) tb_mem[buf_addr] <= buf_w_data;
   assign buf_r_data = tb_mem[buf_addr];

   int          n_vec = 0;
   int          n_err = 0;
   logic [35:0] exp_q [$];
   int          starts_seen = 0;
   bit          mon_en = 1'b0;
   logic [31:0] model_buf [128];
   int          err_permil = 0;
   bit          rdy_full = 1'b0;
   bit          fix_data = 1'b0;
   bit          dir_wr = 1'b0;
   int          dir_word = 0;
   int          dir_left = 0;
   logic [5:0]  dir_code = 6'd0;
   bit          rst_armed = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] ctl();
      return {sd_start, sd_load_enable, buf_w_enable, buf_r_enable, busy, done};
   endfunction

   function automatic logic [5:0] cardmask(input logic [2:0] sel);
      return {{2{sel[2]}}, {2{sel[1]}}, {2{sel[0]}}};
   endfunction

   function automatic logic [5:0] pick_err(input logic [2:0] sel);
      logic [5:0] v;
      do v = 6'($urandom_range(63)) & cardmask(sel); while (v == 6'd0);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      if (fix_data) begin
         sd1out = 32'hAAAA5555;
         sd3out = 32'h0000FFFF;
      end else begin
         sd1out = $urandom;
         sd3out = $urandom;
      end
      sd2out = $urandom;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, 64'({ctl(), sd_mode, sd_sel, error}), 64'd0);
      chk({tag, "_blk"}, 64'(sd_block_no), 64'd0);
      chk({tag, "_addr"}, 64'(buf_addr), 64'd0);
      chk({tag, "_sdone"}, 64'(stripes_done), 64'd0);
      chk({tag, "_data"}, {sd_wdata, buf_w_data}, 64'd0);
   endtask

   // Start descriptor scoreboard: {mode, sel, block}.
   always @(negedge clk) begin
      logic [35:0] e;
      if (mon_en && sd_start === 1'b1) begin
         starts_seen++;
         if (exp_q.size() == 0) chk("start_unexpected", 64'd1, 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("start_desc", 64'({sd_mode, sd_sel, sd_block_no}), 64'(e));
         end
      end
   end

   // One read or write phase of a stripe; status 0 ok, 1 third error, 2 reset abort.
   task automatic run_phase(input int fsd, input bit wr, input logic [31:0] blk,
                            input int s, output int status);
      int          retries;
      int          w;
      bit          ee;
      logic [2:0]  fail_bit;
      logic [2:0]  sel;
      logic [31:0] x;
      retries  = 0;
      status   = 0;
      fail_bit = 3'b001 << (fsd - 1);
      sel      = wr ? fail_bit : (3'b111 ^ fail_bit);
      forever begin
         exp_q.push_back({wr, sel, blk});
         start    = 1'b0;
         sd_ready = 1'($urandom_range(1));
         sd_error = 6'($urandom_range(63));
         rand_data();
         @(negedge clk);
         chk("start_ctl", 64'(ctl()), 64'(6'b100010));
         chk("start_err", 64'(error), 64'd0);
         chk("start_sdone", 64'(stripes_done), 64'(s));
         tick();
         w = 0;
         while (w < 128) begin
            if (rst_armed && !wr && w == 64) begin
               n_rst = 1'b0;
               start = 1'b0;
               tick();
               @(negedge clk);
               check_zero("rst_mid");
               tick();
               n_rst     = 1'b1;
               rst_armed = 1'b0;
               repeat (3) begin
                  @(negedge clk);
                  chk("rst_quiet", 64'(ctl()), 64'd0);
                  tick();
               end
               status = 2;
               return;
            end
            start      = 1'($urandom_range(1));
            failed_sd  = 2'($urandom_range(3));
            base_blk   = $urandom;
            stripe_cnt = 11'($urandom_range(2047));
            sd_ready   = rdy_full ? 1'b1 : ($urandom_range(3) != 0);
            sd_error   = ($urandom_range(9) == 0) ? (6'($urandom_range(63)) & ~cardmask(sel)) : 6'd0;
            if (err_permil > 0 && $urandom_range(999) < err_permil) sd_error = sd_error | pick_err(sel);
            if (dir_left > 0 && dir_wr == wr && w == dir_word) begin
               sd_error = dir_code;
               dir_left--;
            end
            rand_data();
            ee = |(sd_error & cardmask(sel));
            x  = 32'd0;
            if (fsd != 1) x = x ^ sd1out;
            if (fsd != 2) x = x ^ sd2out;
            if (fsd != 3) x = x ^ sd3out;
            @(negedge clk);
            chk("xfer_ctl", 64'(ctl()),
                64'({1'b0, sd_ready & ~ee, ~wr & sd_ready & ~ee, wr, 1'b1, 1'b0}));
            chk("xfer_err", 64'(error), 64'd0);
            if (!wr && sd_ready && !ee) begin
               chk("rd_addr", 64'(buf_addr), 64'(w));
               chk("rd_data", 64'(buf_w_data), 64'(x));
               model_buf[w] = x;
            end
            if (wr) begin
               chk("wr_addr", 64'(buf_addr), 64'(w));
               chk("wr_data", 64'(sd_wdata), 64'(model_buf[w]));
            end
            tick();
            if (ee) begin
               retries++;
               break;
            end else if (sd_ready) begin
               w++;
            end
         end
         if (w == 128) return;
         if (retries == 3) begin
            status = 1;
            return;
         end
      end
   endtask

   task automatic rebuild(input int fsd, input logic [31:0] base, input int cnt);
      int status;
      start      = 1'b1;
      failed_sd  = 2'(fsd);
      base_blk   = base;
      stripe_cnt = 11'(cnt);
      sd_ready   = 1'($urandom_range(1));
      sd_error   = 6'($urandom_range(63));
      rand_data();
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      tick();
      start      = 1'b0;
      failed_sd  = 2'($urandom_range(3));
      base_blk   = $urandom;
      stripe_cnt = 11'($urandom_range(2047));
      status     = 0;
      if (fsd == 0) begin
         repeat (4) begin
            @(negedge clk);
            chk("ignored_start", 64'(ctl()), 64'd0);
            tick();
         end
         return;
      end
      for (int s = 0; s < cnt; s++) begin
         run_phase(fsd, 1'b0, base + 32'(s), s, status);
         if (status != 0) break;
         run_phase(fsd, 1'b1, base + 32'(s), s, status);
         if (status != 0) break;
         start = 1'b0;
         @(negedge clk);
         chk("next_ctl", 64'(ctl()), 64'(6'b000010));
         chk("next_sdone", 64'(stripes_done), 64'(s));
         tick();
      end
      start = 1'b0;
      if (status == 1) begin
         @(negedge clk);
         chk("err_ctl", 64'(ctl()), 64'(6'b000010));
         tick();
         @(negedge clk);
         chk("err_idle", 64'({ctl(), error}), 64'(7'b0000001));
         tick();
      end else if (status == 0) begin
         @(negedge clk);
         chk("done_ctl", 64'(ctl()), 64'(6'b000011));
         chk("done_sdone", 64'(stripes_done), 64'(cnt));
         chk("done_err", 64'(error), 64'd0);
         tick();
         @(negedge clk);
         chk("after_done", 64'({ctl(), error}), 64'd0);
         chk("hold_sdone", 64'(stripes_done), 64'(cnt));
         tick();
      end
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      n_rst      = 1'b0;
      start      = 1'b0;
      failed_sd  = 2'd0;
      base_blk   = 32'd0;
      stripe_cnt = 11'd0;
      sd_ready   = 1'b0;
      sd_error   = 6'd0;
      sd1out     = 32'd0;
      sd2out     = 32'd0;
      sd3out     = 32'd0;
      for (int i = 0; i < 128; i++) begin
         tb_mem[i]    = 32'd0;
         model_buf[i] = 32'd0;
      end
      repeat (3) tick();
      sd_ready = 1'b1;
      sd_error = 6'h3F;
      @(negedge clk);
      check_zero("reset");
      mon_en = 1'b1;
      tick();
      n_rst = 1'b1;
      tick();

      // Single stripe, fixed data, card 2 rebuilt.
      rdy_full = 1'b1;
      fix_data = 1'b1;
      rebuild(2, 32'h100, 1);
      chk("buf_word0", 64'(tb_mem[0]), 64'(32'hAAAAAAAA));
      chk("buf_word127", 64'(tb_mem[127]), 64'(32'hAAAAAAAA));
      chk("sdone_one", 64'(stripes_done), 64'd1);
      fix_data = 1'b0;

      // Block number wraps across stripes; six start pulses.
      rdy_full = 1'b0;
      s0 = starts_seen;
      rebuild(int'($urandom_range(1, 3)), 32'hFFFFFFFF, 3);
      chk("start_count", 64'(starts_seen - s0), 64'd6);

      // One read error on sd1 at word 50, then clean completion.
      rdy_full = 1'b1;
      dir_wr   = 1'b0;
      dir_word = 50;
      dir_left = 1;
      dir_code = 6'b000001;
      rebuild(3, 32'h2000, 1);
      chk("retry_clean", 64'(error), 64'd0);

      // Three write errors on the failed card end in ERR.
      dir_wr   = 1'b1;
      dir_word = 10;
      dir_left = 3;
      dir_code = 6'b000010;
      s0 = starts_seen;
      rebuild(1, 32'h3000, 2);
      chk("err_starts", 64'(starts_seen - s0), 64'd4);
      chk("err_sticky", 64'({busy, error}), 64'(2'b01));

      // Empty rebuild and an illegal card number.
      rebuild(1, 32'h4000, 0);
      rebuild(0, 32'h5000, 2);

      // Reset mid read, then a fresh rebuild completes.
      rst_armed = 1'b1;
      rebuild(2, 32'h6000, 1);
      rdy_full = 1'b0;
      rebuild(2, 32'h6000, 1);

      // Randomized rebuilds with occasional errors on active cards.
      err_permil = 4;
      for (int r = 0; r < 8; r++) begin
         rdy_full = 1'($urandom_range(1));
         rebuild(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/raid_rebuild_ctrl.md
RAID_REBUILD_CTRL -- requirements
Module: raid_rebuild_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports clk and n_rst are listed first.
REQ-002 The block SHALL have these ports:
  clk  in  1  system clock
  n_rst  in  1  synchronous active-low reset
  start  in  1  one-cycle rebuild request; sampled only in IDLE
  failed_sd  in  2  card to rebuild, 1..3; 0 is illegal
  base_blk  in  32  first block number
  stripe_cnt  in  11  stripes to rebuild
  sd_ready  in  1  one word transferred this cycle
  sd_error  in  6  {sd3,sd2,sd1} 2-bit error codes; nonzero means error
  sd1out, sd2out, sd3out  in  32 each  card read data
  buf_r_data  in  32  buffer read data, combinational from buf_addr
  sd_start  out  1  one-cycle transfer start pulse
  sd_mode  out  1  0 = read, 1 = write
  sd_sel  out  3  one-hot targeted cards
  sd_block_no  out  32  block number of current transfer
  sd_load_enable  out  1  word accepted this cycle
  sd_wdata  out  32  write data to the failed card
  buf_w_enable, buf_r_enable  out  1 each  buffer strobes
  buf_addr  out  7  buffer word address
  buf_w_data  out  32  XOR of the surviving cards
  busy  out  1  not in IDLE
  done  out  1  one-cycle completion pulse
  error  out  1  sticky failure flag
  stripes_done  out  11  completed stripes

Function
REQ-003 States SHALL be IDLE, RD_START, RD_XFER, WR_START, WR_XFER, NEXT, DONE, ERR.
REQ-004 IDLE SHALL go to RD_START when start=1, failed_sd!=0 and stripe_cnt!=0.
REQ-005 IDLE SHALL go to DONE when start=1, failed_sd!=0 and stripe_cnt=0.
REQ-006 Start with failed_sd=0 SHALL be ignored.
REQ-007 On accepted start, failed_sd, base_blk and stripe_cnt SHALL be latched; later changes SHALL have no effect.
REQ-008 RD_START SHALL assert sd_start=1 and sd_mode=0 for exactly one cycle, with sd_sel = the two surviving cards, then enter RD_XFER.
REQ-009 In RD_XFER, each cycle with sd_ready=1 SHALL:
  assert sd_load_enable and buf_w_enable;
  drive buf_addr = word counter;
  drive buf_w_data = XOR of the two survivors' data;
  increment the word counter.
REQ-010 A ready word at counter=127 SHALL end RD_XFER: counter wraps to 0, state goes to WR_START.
REQ-011 WR_START SHALL pulse sd_start with sd_mode=1 and sd_sel = the failed card only.
REQ-012 In WR_XFER, each cycle SHALL drive buf_r_enable=1, buf_addr = counter and sd_wdata = buf_r_data.
REQ-013 In WR_XFER, each cycle with sd_ready=1 SHALL assert sd_load_enable and increment the counter; a ready word at 127 SHALL go to NEXT.
REQ-014 sd_block_no SHALL equal latched base_blk + stripes_done, with 32-bit wrap.
REQ-015 NEXT SHALL increment stripes_done, then:
  go to RD_START if stripes_done+1 < stripe_cnt;
  otherwise go to DONE.
REQ-016 DONE SHALL pulse done for one cycle and return to IDLE; stripes_done SHALL hold until the next accepted start clears it.
REQ-017 During XFER states, only the error fields of the cards in sd_sel SHALL count; errors on other cards SHALL be ignored.
REQ-018 A nonzero error during RD_XFER or WR_XFER SHALL:
  clear the word counter;
  increment a 2-bit retry counter;
  re-enter the same phase's START state.
REQ-019 The third error within one phase SHALL enter ERR; error SHALL set and stay set until the next accepted start.
REQ-020 The retry counter SHALL clear on each phase entry from a different phase, i.e. RD_START from IDLE or NEXT, and WR_START from RD_XFER.
REQ-021 If an error and sd_ready occur in the same cycle, the error SHALL win: no write strobe, no counter increment.
REQ-022 ERR SHALL return to IDLE after one cycle without pulsing done.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Strobes and sd_load_enable SHALL be 0 outside their XFER states.

Reset
REQ-025 While n_rst=0 at a clock edge, the state SHALL be IDLE.
REQ-026 On that edge, all counters, latched registers and outputs SHALL be 0 (sd_block_no, buf_addr, stripes_done, error included).
REQ-027 A reset mid-transfer SHALL abort at once: no further sd_start or buffer strobes until a new start.

Verification
REQ-028 failed_sd=2, base_blk=0x100, stripe_cnt=1, sd_ready held 1, sd1out=0xAAAA5555, sd3out=0x0000FFFF -> expect:
  read start with sd_sel=101 and block 0x100;
  128 buffer writes of 0xAAAAAAAA;
  write start with sd_sel=010 and block 0x100;
  128 write words;
  done pulse; stripes_done=1.
REQ-029 stripe_cnt=3, base_blk=0xFFFFFFFF -> expect sd_block_no sequence 0xFFFFFFFF, 0, 1 and exactly 6 sd_start pulses.
REQ-030 sd1_error=01 at word 50 of a read with failed_sd=3 -> expect counter reset, read restarted from word 0, then completion with no error.
REQ-031 Three errors in one write phase -> expect ERR, error=1, no done pulse, busy=0 afterwards.
REQ-032 stripe_cnt=0 -> expect done after 2 cycles with no sd_start; failed_sd=0 -> expect start ignored and busy stays 0.
REQ-033 n_rst=0 at word 64 -> expect all outputs 0 on the next edge, then a new start completes normally.
